// File: rtl/framer_pkg.sv
// framer_pkg: definitions shared by the sample framer and the FFT front end.
//   SAMPLE_W  : default ADC sample width in bits
//   FRAME_LEN : default samples per frame (power of 2, minimum 4)
//   sample_t  : one ADC sample
//   bank_t    : ping-pong bank selector
package framer_pkg;
  localparam int SAMPLE_W  = 24;
  localparam int FRAME_LEN = 256;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic                bank_t;
endpackage

// File: rtl/framer_ram.sv
// framer_ram: simple dual-port RAM holding both ping-pong banks.
//   clk     : clock
//   we      : write enable
//   wr_addr : write address, bank in the MSB
//   wr_data : write data
//   rd_addr : read address, bank in the MSB
//   rd_data : read data, registered (1-cycle latency)
// There is no reset on the array or on the read register, so the
// block-RAM output register can absorb the read flop.
module framer_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_framer.sv
// sample_framer: captures ADC samples on each advance strobe, optionally
// decimates them, and packs them into ping-pong frames for the FFT reader.
//   CLOCK_50    : system clock
//   reset       : asynchronous active-low reset
//   advance     : sample strobe, asynchronous, high for one or more cycles
//   sample_in   : ADC sample, stable between advance rising edges
//   enable      : capture enable; low discards any partial frame
//   frame_ack   : reader releases the frame it holds
//   rd_addr     : read index within the ready frame
//   rd_data     : registered read data (1-cycle latency)
//   frame_ready : a complete frame is held for the reader
//   rd_bank     : bank currently owned by the reader
//   overrun     : sticky, a completed frame could not be handed over
//   clr_overrun : clears overrun
//   frame_count : frames handed to the reader, modulo 2^16
module sample_framer #(
  parameter int SAMPLE_W  = framer_pkg::SAMPLE_W,
  parameter int FRAME_LEN = framer_pkg::FRAME_LEN,
  parameter int DECIM     = 1,
  parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                advance,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                enable,
  input  logic                frame_ack,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                frame_ready,
  output logic                rd_bank,
  output logic                overrun,
  input  logic                clr_overrun,
  output logic [15:0]         frame_count
);

  import framer_pkg::*;

  // Writer position within the frame.
  localparam logic WR_FILL = 1'b0;
  localparam logic WR_LAST = 1'b1;
  // Reader ownership of the presented frame.
  localparam logic OWN_FREE = 1'b0;
  localparam logic OWN_HELD = 1'b1;

  logic                sync1_reg, sync2_reg, sync3_reg;
  logic [ADDR_W-1:0]   wr_ptr_reg;
  bank_t               wr_bank_reg;
  bank_t               rd_bank_reg;
  logic [7:0]          decim_cnt_reg;
  logic                frame_ready_reg;
  logic                overrun_reg;
  logic [15:0]         frame_count_reg;
  logic                rd_live_reg;
  logic [SAMPLE_W-1:0] ram_q;

  logic strobe, accept, write_en, frame_done, handoff;
  logic wr_state, own_state;

  // sync3 is the edge-detector history flop behind the 2-flop synchronizer.
  assign strobe     = sync2_reg & ~sync3_reg;
  assign accept     = strobe & enable;
  assign write_en   = accept && (decim_cnt_reg == 8'd0);
  assign wr_state   = (wr_ptr_reg == ADDR_W'(FRAME_LEN - 1)) ? WR_LAST : WR_FILL;
  assign own_state  = frame_ready_reg ? OWN_HELD : OWN_FREE;
  assign frame_done = write_en && (wr_state == WR_LAST);
  // An ack in the completion cycle frees the reader bank just in time.
  assign handoff    = frame_done && ((own_state == OWN_FREE) || frame_ack);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
    end else begin
      sync1_reg <= advance;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      decim_cnt_reg <= 8'd0;
    end else if (!enable) begin
      wr_ptr_reg    <= '0;
      decim_cnt_reg <= 8'd0;
    end else if (accept) begin
      decim_cnt_reg <= (decim_cnt_reg == 8'(DECIM - 1)) ? 8'd0 : decim_cnt_reg + 8'd1;
      if (write_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;  // natural wrap at frame end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_bank_reg     <= 1'b0;
      rd_bank_reg     <= 1'b0;
      frame_ready_reg <= 1'b0;
      frame_count_reg <= 16'd0;
    end else if (handoff) begin
      rd_bank_reg     <= wr_bank_reg;
      wr_bank_reg     <= ~wr_bank_reg;
      frame_ready_reg <= 1'b1;
      frame_count_reg <= frame_count_reg + 16'd1;
    end else if (frame_ack && frame_ready_reg && !frame_done) begin
      frame_ready_reg <= 1'b0;
    end
  end

  // A dropped frame keeps wr_bank, so the next frame overwrites the same bank.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      overrun_reg <= 1'b0;
    end else if (frame_done && !handoff) begin
      overrun_reg <= 1'b1;
    end else if (clr_overrun) begin
      overrun_reg <= 1'b0;
    end
  end

  // The RAM read register has no reset; this flag forces rd_data to zero
  // from reset until the first clock has loaded real data.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      rd_live_reg <= 1'b0;
    end else begin
      rd_live_reg <= 1'b1;
    end
  end

  framer_ram #(
    .DATA_W (SAMPLE_W),
    .ADDR_W (ADDR_W + 1)
  ) u_ram (
    .clk     (CLOCK_50),
    .we      (write_en),
    .wr_addr ({wr_bank_reg, wr_ptr_reg}),
    .wr_data (sample_in),
    .rd_addr ({rd_bank_reg, rd_addr}),
    .rd_data (ram_q)
  );

  assign rd_data     = rd_live_reg ? ram_q : '0;
  assign frame_ready = frame_ready_reg;
  assign rd_bank     = rd_bank_reg;
  assign overrun     = overrun_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_sample_framer.sv
module tb_sample_framer;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        advance;
  logic [23:0] sample_in;
  logic        enable;
  logic        frame_ack;
  logic [7:0]  rd_addr;
  logic        clr_overrun;

  logic [23:0] rd_data,  rd_data4;
  logic        frame_ready, frame_ready4;
  logic        rd_bank, rd_bank4;
  logic        overrun, overrun4;
  logic [15:0] frame_count, frame_count4;

  int checks   = 0;
  int failures = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  sample_framer u_dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .advance     (advance),
    .sample_in   (sample_in),
    .enable      (enable),
    .frame_ack   (frame_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ready (frame_ready),
    .rd_bank     (rd_bank),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .frame_count (frame_count)
  );

  sample_framer #(.DECIM(4)) u_dec (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .advance     (advance),
    .sample_in   (sample_in),
    .enable      (enable),
    .frame_ack   (frame_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data4),
    .frame_ready (frame_ready4),
    .rd_bank     (rd_bank4),
    .overrun     (overrun4),
    .clr_overrun (clr_overrun),
    .frame_count (frame_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %s obs=%0d exp=%0d", tag, obs, exp);
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One advance pulse. advance rises just after edge E0; the write happens
  // on edge E3. With ack=1, frame_ack is high only in the E2..E3 cycle.
  task automatic pulse(input int v, input int hold, input bit ack);
    @(posedge CLOCK_50); #1;
    sample_in = 24'(v);
    advance   = 1'b1;
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1;
    if (ack) frame_ack = 1'b1;
    @(posedge CLOCK_50); #1;
    frame_ack = 1'b0;
    if (hold > 3) repeat (hold - 3) @(posedge CLOCK_50);
    #1 advance = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    advance = 1'b0; frame_ack = 1'b0; clr_overrun = 1'b0; enable = 1'b1;
    @(posedge CLOCK_50); #1;
    reset = 1'b1;
  endtask

  // Returns read data for addr from both instances after the 1-cycle latency.
  task automatic rd(input int a, output logic [23:0] d1, output logic [23:0] d4);
    @(posedge CLOCK_50); #1;
    rd_addr = 8'(a);
    @(posedge CLOCK_50); #1;
    d1 = rd_data;
    d4 = rd_data4;
  endtask

  initial begin
    logic [23:0] d1, d4;
    reset = 1'b0; advance = 1'b0; sample_in = '0; enable = 1'b0;
    frame_ack = 1'b0; rd_addr = '0; clr_overrun = 1'b0;

    // Reset state
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_ready", frame_ready, 0);
    chk("rst_bank",  rd_bank, 0);
    chk("rst_ovr",   overrun, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_data",  rd_data, 0);
    @(negedge CLOCK_50) reset = 1'b1;

    // Test 1: first frame 0..255
    enable = 1'b1;
    for (int i = 0; i < 255; i++) pulse(i, 3, 1'b0);
    chk("t1_ready_255", frame_ready, 0);
    pulse(255, 3, 1'b0);
    chk("t1_ready", frame_ready, 1);
    chk("t1_bank",  rd_bank, 0);
    chk("t1_count", frame_count, 1);
    chk("t1_ovr",   overrun, 0);
    for (int i = 0; i < 256; i++) begin
      rd(i, d1, d4);
      chk("t1_rd", d1, i);
    end

    // Test 2: ack, then second frame 1000..1255 into bank 1
    @(posedge CLOCK_50); #1 frame_ack = 1'b1;
    @(posedge CLOCK_50); #1 frame_ack = 1'b0;
    chk("t2_ready_fall", frame_ready, 0);
    for (int i = 0; i < 256; i++) pulse(1000 + i, 3, 1'b0);
    chk("t2_ready", frame_ready, 1);
    chk("t2_bank",  rd_bank, 1);
    chk("t2_count", frame_count, 2);
    rd(5, d1, d4);
    chk("t2_rd5", d1, 1005);
    rd(0, d1, d4);
    chk("t2_rd0", d1, 1000);

    // Test 3: overrun after 512 writes with no ack
    do_reset();
    for (int i = 0; i < 511; i++) pulse((i < 256) ? i : 2000 + i, 3, 1'b0);
    chk("t3_ovr_511", overrun, 0);
    pulse(2511, 3, 1'b0);
    chk("t3_ovr",   overrun, 1);
    chk("t3_count", frame_count, 1);
    chk("t3_ready", frame_ready, 1);
    chk("t3_bank",  rd_bank, 0);
    for (int i = 0; i < 256; i += 17) begin
      rd(i, d1, d4);
      chk("t3_rd", d1, i);
    end
    rd(255, d1, d4);
    chk("t3_rd255", d1, 255);
    @(posedge CLOCK_50); #1 clr_overrun = 1'b1;
    @(posedge CLOCK_50); #1 clr_overrun = 1'b0;
    chk("t3_clr", overrun, 0);

    // Test 4: ack coincides with the 512th write
    do_reset();
    for (int i = 0; i < 256; i++) pulse(i, 3, 1'b0);
    for (int i = 0; i < 255; i++) pulse(3000 + i, 3, 1'b0);
    chk("t4_ready_pre", frame_ready, 1);
    pulse(3255, 3, 1'b1);
    chk("t4_ovr",   overrun, 0);
    chk("t4_ready", frame_ready, 1);
    chk("t4_bank",  rd_bank, 1);
    chk("t4_count", frame_count, 2);
    rd(7, d1, d4);
    chk("t4_rd7", d1, 3007);

    // Test 5: DECIM=4 instance, advance held 10 cycles per pulse
    do_reset();
    for (int i = 0; i < 1020; i++) pulse(i, 10, 1'b0);
    chk("t5_ready_1020", frame_ready4, 0);
    pulse(1020, 10, 1'b0);
    chk("t5_ready", frame_ready4, 1);
    for (int i = 1021; i < 1024; i++) pulse(i, 10, 1'b0);
    chk("t5_count", frame_count4, 1);
    chk("t5_ovr",   overrun4, 0);
    rd(0, d1, d4);   chk("t5_rd0",   d4, 0);
    rd(1, d1, d4);   chk("t5_rd1",   d4, 4);
    rd(100, d1, d4); chk("t5_rd100", d4, 400);
    rd(255, d1, d4); chk("t5_rd255", d4, 1020);

    // Test 6a: asynchronous reset mid-frame
    do_reset();
    for (int i = 0; i < 356; i++) pulse(i + 7, 3, 1'b0);
    rd(5, d1, d4);
    chk("t6_rd_pre", d1, 12);
    chk("t6_ready_pre", frame_ready, 1);
    #3 reset = 1'b0;
    #1;
    chk("t6_async_ready", frame_ready, 0);
    chk("t6_async_count", frame_count, 0);
    chk("t6_async_data",  rd_data, 0);
    chk("t6_async_bank",  rd_bank, 0);
    @(negedge CLOCK_50) reset = 1'b1;
    for (int i = 0; i < 255; i++) pulse(i, 3, 1'b0);
    chk("t6_ready_255", frame_ready, 0);
    pulse(255, 3, 1'b0);
    chk("t6_ready", frame_ready, 1);
    chk("t6_count", frame_count, 1);

    // Test 6b: enable drop discards the partial frame
    do_reset();
    for (int i = 0; i < 100; i++) pulse(4000 + i, 3, 1'b0);
    @(posedge CLOCK_50); #1 enable = 1'b0;
    pulse(4500, 3, 1'b0);
    @(posedge CLOCK_50); #1 enable = 1'b1;
    for (int i = 0; i < 255; i++) pulse(5000 + i, 3, 1'b0);
    chk("t6b_ready_255", frame_ready, 0);
    pulse(5255, 3, 1'b0);
    chk("t6b_ready", frame_ready, 1);
    rd(0, d1, d4);
    chk("t6b_rd0", d1, 5000);
    rd(255, d1, d4);
    chk("t6b_rd255", d1, 5255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
